// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, fetches from a combinational-read
// instruction memory into a small circular queue, and hands entries to decode
// over a valid/ready handshake. Redirects flush the queue and re-steer fetch.
// Fetch halts at the end of the image; a misaligned redirect faults (sticky).
module fetch_sequencer #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          MEM_BYTES = 112,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        halted,
    output logic        fault
);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_q_pc    [DEPTH];
    logic [31:0]     r_q_instr [DEPTH];

    logic            w_in_range;
    logic            w_pop;
    logic            w_push;

    // Circular pointer advance; DEPTH need not fill the pointer width when DEPTH=1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (32'(p) == DEPTH - 1) return '0;
        else                     return p + PW'(1);
    endfunction

    assign imem_pc    = r_fetch_pc;
    assign out_valid  = (r_count != '0);
    assign out_pc     = r_q_pc[r_rd];
    assign out_instr  = r_q_instr[r_rd];
    assign halted     = (r_state == HALT);
    assign fault      = (r_state == FAULT);

    assign w_in_range = (r_fetch_pc <= LAST_PC);
    assign w_pop      = out_valid & out_ready;
    // Pop-bypass lets a full queue still accept a fetch, giving one/cycle at DEPTH=1.
    assign w_push     = (r_state == RUN) && !redirect_valid && w_in_range &&
                        ((r_count < CW'(DEPTH)) || w_pop);

    // State machine, PC and queue update; redirect outranks fetch, reset outranks all.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_fetch_pc <= PC_RESET;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (r_state != FAULT) begin
            if (redirect_valid) begin
                // Flush: a same-cycle pop is still consumed by decode, nothing to undo.
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                if (redirect_pc[1:0] == 2'b00) begin
                    r_fetch_pc <= redirect_pc;
                    r_state    <= RUN;
                end else begin
                    r_state    <= FAULT;
                end
            end else if (r_state == RUN) begin
                if (w_push) begin
                    r_q_pc[r_wr]    <= r_fetch_pc;
                    r_q_instr[r_wr] <= imem_instr;
                    r_wr            <= ptr_inc(r_wr);
                    r_fetch_pc      <= r_fetch_pc + 32'd4;
                end
                if (w_pop) r_rd <= ptr_inc(r_rd);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                // Past the image with nothing left to deliver: done.
                if (!w_in_range && r_count == '0) r_state <= HALT;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, end of image, backpressure,
// redirect with full queue, misaligned fault, leaving HALT, out-of-range redirect.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        halted;
    logic        fault;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_RESET(32'h0), .MEM_BYTES(112), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .halted(halted), .fault(fault)
    );

    // Program image: a few fixed words, the rest a recognisable pattern.
    function automatic logic [31:0] img(input logic [31:0] pc);
        logic [31:0] idx;
        idx = pc >> 2;
        if (pc >= 32'd112) return 32'h0;
        case (idx)
            32'd0:   return 32'h0020_81B3;
            32'd1:   return 32'h0020_91B3;
            32'd10:  return 32'h0002_02CC;
            32'd18:  return 32'h0000_8155;
            default: return 32'hA500_0000 | idx;
        endcase
    endfunction

    assign imem_instr = img(imem_pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick; tick;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc",    out_pc,         32'd0);
        chk("rst_instr", out_instr,      32'd0);
        chk("rst_halt",  32'(halted),    32'd0);
        chk("rst_fault", 32'(fault),     32'd0);
        chk("rst_imem",  imem_pc,        32'd0);

        // Streaming
        reset = 1'b0; out_ready = 1'b1;
        chk("first_cycle_valid", 32'(out_valid), 32'd0);
        tick;
        chk("s0_valid", 32'(out_valid), 32'd1);
        chk("s0_pc",    out_pc,         32'd0);
        chk("s0_instr", out_instr,      32'h0020_81B3);
        tick;
        chk("s1_pc",    out_pc,         32'd4);
        chk("s1_instr", out_instr,      32'h0020_91B3);
        for (int k = 2; k < 28; k++) begin
            tick;
            chk("sk_valid", 32'(out_valid), 32'd1);
            chk("sk_pc",    out_pc,         32'(4 * k));
            chk("sk_instr", out_instr,      img(32'(4 * k)));
        end

        // End of image
        tick;
        chk("eoi_valid", 32'(out_valid), 32'd0);
        chk("eoi_halt0", 32'(halted),    32'd0);
        chk("eoi_imem",  imem_pc,        32'd112);
        tick;
        chk("eoi_halt1", 32'(halted),    32'd1);
        chk("eoi_imem2", imem_pc,        32'd112);
        tick;
        chk("halt_valid", 32'(out_valid), 32'd0);
        chk("halt_hold",  32'(halted),    32'd1);

        // Leave HALT via redirect to 40
        redirect_valid = 1'b1; redirect_pc = 32'd40;
        tick;
        redirect_valid = 1'b0;
        chk("lh_halt",  32'(halted),    32'd0);
        chk("lh_valid", 32'(out_valid), 32'd0);
        tick;
        chk("lh_valid2", 32'(out_valid), 32'd1);
        chk("lh_pc",     out_pc,         32'd40);
        chk("lh_instr",  out_instr,      32'h0002_02CC);

        // Backpressure from a fresh reset
        reset = 1'b1; out_ready = 1'b0;
        tick;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc",    out_pc,         32'd0);
        end
        chk("bp_imem", imem_pc, 32'd8);
        out_ready = 1'b1;
        chk("rel0_pc", out_pc, 32'd0);
        tick;
        chk("rel1_pc", out_pc, 32'd4);
        tick;
        chk("rel2_pc", out_pc, 32'd8);

        // Queue full (8,12); redirect to 72 while popping 8
        redirect_valid = 1'b1; redirect_pc = 32'd72;
        tick;
        redirect_valid = 1'b0;
        chk("rd_valid0", 32'(out_valid), 32'd0);
        chk("rd_imem",   imem_pc,        32'd72);
        tick;
        chk("rd_valid1", 32'(out_valid), 32'd1);
        chk("rd_pc",     out_pc,         32'd72);
        chk("rd_instr",  out_instr,      32'h0000_8155);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h4A;
        tick;
        chk("mis_fault", 32'(fault),     32'd1);
        chk("mis_valid", 32'(out_valid), 32'd0);
        chk("mis_imem",  imem_pc,        32'd76);
        redirect_pc = 32'd0;
        tick;
        redirect_valid = 1'b0;
        chk("flt_fault", 32'(fault),     32'd1);
        chk("flt_imem",  imem_pc,        32'd76);
        tick;
        chk("flt_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("clr_fault", 32'(fault),     32'd0);
        chk("clr_imem",  imem_pc,        32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        tick;
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_pc",    out_pc,         32'd0);

        // Aligned redirect beyond the image: RUN with empty queue, then HALT
        redirect_valid = 1'b1; redirect_pc = 32'd200;
        tick;
        redirect_valid = 1'b0;
        chk("oor_halt0",  32'(halted),    32'd0);
        chk("oor_valid",  32'(out_valid), 32'd0);
        chk("oor_imem",   imem_pc,        32'd200);
        tick;
        chk("oor_halt1",  32'(halted),    32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
